ahb_bus_arbiter: RTL and testbench

//  Bus-side responder to the DMAC master handshake: takes Bus_Req from each AHB master
//  (DMAC and CPU) and returns a registered one-hot Bus_Grant. Drives the address-phase

---
 rtl/ahb_bus_arbiter.sv | 91 +++++++++
 tb/tb_ahb_bus_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ahb_bus_arbiter.sv
// Fixed-priority AHB bus arbiter with tenure limit and locked-transfer support.
// Drives a registered one-hot grant plus the address- and data-phase owner indices.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int DEFAULT_MASTER = 1,
  parameter int TENURE_MAX     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_MASTERS-1:0]         Bus_Req,
  input  logic [NUM_MASTERS-1:0]         HLock,
  input  logic [1:0]                     HTrans,
  input  logic                           HReady,
  output logic [NUM_MASTERS-1:0]         Bus_Grant,
  output logic [$clog2(NUM_MASTERS)-1:0] HMaster,
  output logic                           HMastLock,
  output logic [$clog2(NUM_MASTERS)-1:0] HMasterData
);

  localparam int MW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(TENURE_MAX + 1);
  localparam logic [MW-1:0] DEF  = MW'(DEFAULT_MASTER);
  localparam logic [CW-1:0] TMAX = CW'(TENURE_MAX);

  typedef enum logic [1:0] {PARK, OWN, LOCKED} state_t;

  state_t          state, state_next;
  logic [MW-1:0]   owner, winner;
  logic [CW-1:0]   tenure_cnt;
  logic            winner_valid, tenure_exp, lock_release, locked;
  logic            rearb_ok, others_req, beat;

  assign tenure_exp   = (tenure_cnt == TMAX);
  // The first ready edge with the lock dropped is already a rearbitration point.
  assign lock_release = (state == LOCKED) & HReady & ~HLock[owner];
  assign locked       = (HMastLock | HLock[owner]) & ~lock_release;
  assign rearb_ok     = HReady & ~locked &
                        ((HTrans == 2'b00) | (HTrans == 2'b10) | tenure_exp);
  assign others_req   = |(Bus_Req & ~Bus_Grant);
  assign beat         = HReady & HTrans[1];

  // Lowest requesting index wins; an expired owner is skipped so others get a turn.
  always_comb begin
    winner       = DEF;
    winner_valid = 1'b0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (Bus_Req[i] && !(tenure_exp && (owner == MW'(i)))) begin
        winner       = MW'(i);
        winner_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    if (HReady && HLock[owner])
      state_next = LOCKED;
    else if (rearb_ok)
      state_next = winner_valid ? OWN : PARK;
    else if (state == LOCKED && HReady)
      state_next = Bus_Req[owner] ? OWN : PARK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PARK;
      Bus_Grant   <= NUM_MASTERS'(1) << DEF;
      owner       <= DEF;
      tenure_cnt  <= '0;
      HMaster     <= DEF;
      HMastLock   <= 1'b0;
      HMasterData <= DEF;
    end else begin
      state <= state_next;
      if (rearb_ok) begin
        Bus_Grant <= NUM_MASTERS'(1) << winner;
        owner     <= winner;
      end
      if (rearb_ok && (winner != owner))
        tenure_cnt <= '0;
      else if (beat && others_req && !tenure_exp)
        tenure_cnt <= tenure_cnt + CW'(1);
      if (HReady) begin
        HMaster     <= owner;
        HMastLock   <= HLock[owner];
        HMasterData <= HMaster;
      end
    end
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: directed scenarios followed by random
// traffic, compared every cycle against an integer-level behavioural model.
module tb_ahb_bus_arbiter;

  localparam int NM   = 2;
  localparam int DEF  = 1;
  localparam int TMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NM-1:0] Bus_Req, HLock;
  logic [1:0]    HTrans;
  logic          HReady;
  logic [NM-1:0] Bus_Grant;
  logic [0:0]    HMaster, HMasterData;
  logic          HMastLock;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int m_owner, m_hmaster, m_hdata, m_lock, m_cnt;

  ahb_bus_arbiter #(.NUM_MASTERS(NM), .DEFAULT_MASTER(DEF), .TENURE_MAX(TMAX)) dut (
    .clk(clk), .rst(rst), .Bus_Req(Bus_Req), .HLock(HLock), .HTrans(HTrans),
    .HReady(HReady), .Bus_Grant(Bus_Grant), .HMaster(HMaster),
    .HMastLock(HMastLock), .HMasterData(HMasterData)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    m_owner = DEF; m_hmaster = DEF; m_hdata = DEF; m_lock = 0; m_cnt = 0;
  endtask

  // One clock edge of the arbitration rules, expressed on integers.
  task automatic modelStep();
    int  winner, new_owner, old_hmaster;
    bit  expired, frozen, ok, others;
    expired = (m_cnt == TMAX);
    frozen  = HLock[m_owner] || (m_lock != 0 && !HReady);
    ok      = HReady && !frozen && (HTrans == 2'b00 || HTrans == 2'b10 || expired);
    winner  = DEF;
    for (int i = 0; i < NM; i++) begin
      if (Bus_Req[i] && !(expired && i == m_owner)) begin
        winner = i;
        break;
      end
    end
    others = 0;
    for (int i = 0; i < NM; i++)
      if (i != m_owner && Bus_Req[i]) others = 1;
    new_owner = ok ? winner : m_owner;
    if (new_owner != m_owner)
      m_cnt = 0;
    else if (HReady && (HTrans == 2'b10 || HTrans == 2'b11) && others && m_cnt < TMAX)
      m_cnt = m_cnt + 1;
    if (HReady) begin
      old_hmaster = m_hmaster;
      m_hmaster   = m_owner;
      m_lock      = HLock[m_owner] ? 1 : 0;
      m_hdata     = old_hmaster;
    end
    m_owner = new_owner;
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic [1:0] lock,
                               input logic [1:0] trans, input logic ready);
    Bus_Req = req; HLock = lock; HTrans = trans; HReady = ready;
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic checkValue(input string tag, input logic [1:0] got, input logic [1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [1:0] eg;
    eg = 2'(1 << m_owner);
    checkValue({tag, " grant"}, Bus_Grant, eg);
    checkValue({tag, " hmaster"}, {1'b0, HMaster}, 2'(m_hmaster));
    checkValue({tag, " hmastlock"}, {1'b0, HMastLock}, 2'(m_lock));
    checkValue({tag, " hmasterdata"}, {1'b0, HMasterData}, 2'(m_hdata));
    checkValue({tag, " onehot"}, {1'b0, $onehot(Bus_Grant)}, 2'b01);
  endtask

  task automatic stepCheck(input string tag, input logic [1:0] req, input logic [1:0] lock,
                           input logic [1:0] trans, input logic ready);
    applyStimulus(req, lock, trans, ready);
    checkOutput(tag);
  endtask

  task automatic doReset();
    rst = 1'b1;
    modelReset();
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset");
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; Bus_Req = '0; HLock = '0; HTrans = 2'b00; HReady = 1'b1;
    modelReset();
    @(posedge clk); @(posedge clk); @(negedge clk);
    checkOutput("T1 reset");
    checkValue("T1 grant const", Bus_Grant, 2'b10);
    rst = 1'b0;

    // T2: DMAC request with the bus idle
    stepCheck("T2 c1", 2'b01, 2'b00, 2'b00, 1'b1);
    checkValue("T2 grant const", Bus_Grant, 2'b01);
    stepCheck("T2 c2", 2'b01, 2'b00, 2'b00, 1'b1);
    checkValue("T2 hmaster const", {1'b0, HMaster}, 2'b00);
    stepCheck("T2 c3", 2'b01, 2'b00, 2'b00, 1'b1);
    checkValue("T2 hmasterdata const", {1'b0, HMasterData}, 2'b00);

    // T3: same request but HReady stalls for three cycles
    doReset();
    stepCheck("T3 c0", 2'b01, 2'b00, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      stepCheck("T3 stall", 2'b01, 2'b00, 2'b00, 1'b0);
      checkValue("T3 hmaster held", {1'b0, HMaster}, 2'b01);
    end
    stepCheck("T3 ready", 2'b01, 2'b00, 2'b00, 1'b1);
    checkValue("T3 hmaster moved", {1'b0, HMaster}, 2'b00);

    // T4: DMAC burst while CPU waits -> forced handover after TMAX beats
    stepCheck("T4 nonseq", 2'b11, 2'b00, 2'b10, 1'b1);
    for (int i = 0; i < TMAX - 1; i++)
      stepCheck("T4 seq", 2'b11, 2'b00, 2'b11, 1'b1);
    checkValue("T4 still dmac", Bus_Grant, 2'b01);
    stepCheck("T4 handover", 2'b11, 2'b00, 2'b11, 1'b1);
    checkValue("T4 grant cpu", Bus_Grant, 2'b10);

    // T5: CPU holds a locked transfer while DMAC requests
    stepCheck("T5 lock", 2'b11, 2'b10, 2'b10, 1'b1);
    stepCheck("T5 lock stall", 2'b11, 2'b10, 2'b11, 1'b0);
    stepCheck("T5 lock seq", 2'b11, 2'b10, 2'b11, 1'b1);
    checkValue("T5 grant frozen", Bus_Grant, 2'b10);
    stepCheck("T5 unlock", 2'b11, 2'b00, 2'b00, 1'b1);
    checkValue("T5 grant dmac", Bus_Grant, 2'b01);

    // T6: everyone drops -> park on the default master, then async reset
    stepCheck("T6 drop", 2'b00, 2'b00, 2'b00, 1'b1);
    checkValue("T6 parked", Bus_Grant, 2'b10);
    stepCheck("T6 dmac", 2'b01, 2'b00, 2'b00, 1'b1);
    stepCheck("T6 dmac2", 2'b01, 2'b00, 2'b10, 1'b1);
    #2 rst = 1'b1;
    modelReset();
    #1 checkOutput("T6 async reset");
    @(posedge clk); @(negedge clk);
    rst = 1'b0;

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [1:0] rq, lk, tr;
      logic       rd;
      rq = 2'($urandom_range(0, 3));
      lk = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      tr = 2'($urandom_range(0, 3));
      rd = ($urandom_range(0, 3) != 0);
      stepCheck("random", rq, lk, tr, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
